// File: rtl/hdc_text_classifier.sv
// hdc_text_classifier: trigram hypervector text encoder with Hamming-distance ham/spam decision
module hdc_text_classifier #(
  parameter int MAX_LENGTH = 160,
  parameter int D = 256,
  parameter int LEN_W = 8,
  parameter logic [D-1:0] SEED = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MAX_LENGTH*8-1:0]   msg,
  input  logic [LEN_W-1:0]          length,
  input  logic                      label,
  input  logic [D-1:0]              ham_hv,
  input  logic [D-1:0]              spam_hv,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                result,
  output logic                      correct,
  output logic [$clog2(D+1)-1:0]    dist_ham,
  output logic [$clog2(D+1)-1:0]    dist_spam
);
  localparam int CW = $clog2(MAX_LENGTH + 1);
  localparam int DW = $clog2(D + 1);
  typedef enum logic [2:0] {IDLE, LOAD, ACCUM, THRESH, COMPARE, DONE} state_t;
  state_t state_q, state_d;
  logic [MAX_LENGTH*8-1:0] msg_q;
  logic [LEN_W-1:0] len_q, idx;
  logic lbl_q;
  logic [D-1:0] ham_q, spam_q, query, query_c, trig;
  logic [7:0] ch, h1, h2;
  logic [CW-1:0] cnt [D];
  logic [DW-1:0] dh_c, ds_c;
  logic bad_len, last;
  function automatic logic [D-1:0] rotl(input logic [D-1:0] v, input int n);
    logic [2*D-1:0] w;
    w = {v, v} << (n % D);
    return w[2*D-1 -: D];
  endfunction
  assign ch = msg_q[MAX_LENGTH*8-1-8*int'(idx) -: 8];
  assign trig = rotl(SEED, int'(h2) + 2) ^ rotl(SEED, int'(h1) + 1) ^ rotl(SEED, int'(ch));
  assign bad_len = len_q < LEN_W'(3) || int'(len_q) > MAX_LENGTH;
  assign last = idx == len_q - LEN_W'(1);
  assign dh_c = DW'($countones(query ^ ham_q));
  assign ds_c = DW'($countones(query ^ spam_q));
  // majority threshold over N = length-2 trigrams; a tie yields 0
  always_comb begin
    for (int b = 0; b < D; b++) query_c[b] = 2 * int'(cnt[b]) > int'(len_q) - 2;
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // sequencing; invalid lengths go through COMPARE so both paths share the result write
  always_comb begin
    busy = state_q inside {LOAD, ACCUM, THRESH, COMPARE};
    done = state_q == DONE;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LOAD : IDLE;
      LOAD:    state_d = bad_len ? COMPARE : ACCUM;
      ACCUM:   state_d = last ? THRESH : ACCUM;
      THRESH:  state_d = COMPARE;
      COMPARE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // datapath: latch request, accumulate trigrams, threshold, compare
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_q <= '0;
      len_q <= '0;
      lbl_q <= 1'b0;
      ham_q <= '0;
      spam_q <= '0;
      idx <= '0;
      h1 <= '0;
      h2 <= '0;
      query <= '0;
      result <= 2'b11;
      correct <= 1'b0;
      dist_ham <= '0;
      dist_spam <= '0;
      for (int b = 0; b < D; b++) cnt[b] <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        msg_q <= msg;
        len_q <= length;
        lbl_q <= label;
        ham_q <= ham_hv;
        spam_q <= spam_hv;
      end
      if (state_q == LOAD) begin
        idx <= '0;
        h1 <= '0;
        h2 <= '0;
        for (int b = 0; b < D; b++) cnt[b] <= '0;
      end
      if (state_q == ACCUM) begin
        idx <= idx + LEN_W'(1);
        h2 <= h1;
        h1 <= ch;
        if (idx >= LEN_W'(2))
          for (int b = 0; b < D; b++) cnt[b] <= cnt[b] + CW'(trig[b]);
      end
      if (state_q == THRESH) query <= query_c;
      if (state_q == COMPARE) begin
        result <= bad_len ? 2'b10 : {1'b0, dh_c > ds_c};
        correct <= !bad_len && ((dh_c > ds_c) == lbl_q);
        dist_ham <= bad_len ? '0 : dh_c;
        dist_spam <= bad_len ? '0 : ds_c;
      end
    end
  end
endmodule

// File: tb/tb_hdc_text_classifier.sv
// tb_hdc_text_classifier: three seed variants checked against a bit-index trigram model
module tb_hdc_text_classifier;
  localparam int ML = 160;
  localparam int D = 256;
  localparam int LW = 8;
  localparam int DW = 9;
  localparam logic [D-1:0] S0 = '0;
  localparam logic [D-1:0] S1 = '1;
  localparam logic [D-1:0] S2 = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
  logic clk = 0;
  logic reset, start, label;
  logic [ML*8-1:0] msg;
  logic [LW-1:0] length;
  logic [D-1:0] ham_hv, spam_hv;
  logic busy [3];
  logic done [3];
  logic correct [3];
  logic [1:0] result [3];
  logic [DW-1:0] dist_ham [3];
  logic [DW-1:0] dist_spam [3];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : dut
    hdc_text_classifier #(.MAX_LENGTH(ML), .D(D), .LEN_W(LW), .SEED(g == 0 ? S0 : g == 1 ? S1 : S2)) u (
      .clk(clk), .reset(reset), .start(start), .msg(msg), .length(length), .label(label),
      .ham_hv(ham_hv), .spam_hv(spam_hv), .busy(busy[g]), .done(done[g]), .result(result[g]),
      .correct(correct[g]), .dist_ham(dist_ham[g]), .dist_spam(dist_spam[g])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [D-1:0] seed_of(input int k);
    return k == 0 ? S0 : k == 1 ? S1 : S2;
  endfunction
  function automatic logic [ML*8-1:0] pack(input string s);
    logic [ML*8-1:0] m = '0;
    for (int i = 0; i < s.len(); i++) m[ML*8-1-8*i -: 8] = s[i];
    return m;
  endfunction
  function automatic logic [ML*8-1:0] rand_msg();
    logic [ML*8-1:0] m;
    for (int i = 0; i < ML; i++) m[8*i +: 8] = 8'($urandom);
    return m;
  endfunction
  function automatic logic [D-1:0] rand_hv();
    logic [D-1:0] h;
    for (int i = 0; i < D / 32; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction
  function automatic int popc(input logic [D-1:0] v);
    int n = 0;
    for (int j = 0; j < D; j++) n += int'(v[j]);
    return n;
  endfunction
  // bit j of ROTL(seed, r) is seed[(j - r) mod D]; count trigram ones per bit, then majority
  function automatic logic [D-1:0] model_query(input logic [D-1:0] seed, input logic [ML*8-1:0] m, input int len);
    int cnt [D];
    int c [ML];
    logic [D-1:0] q;
    for (int i = 0; i < ML; i++) c[i] = int'(m[ML*8-1-8*i -: 8]);
    for (int j = 0; j < D; j++) cnt[j] = 0;
    for (int i = 2; i < len; i++)
      for (int j = 0; j < D; j++)
        cnt[j] += int'(seed[(j - 2 - c[i-2] + 2*D) % D] ^ seed[(j - 1 - c[i-1] + 2*D) % D] ^ seed[(j - c[i] + D) % D]);
    for (int j = 0; j < D; j++) q[j] = 2 * cnt[j] > len - 2;
    return q;
  endfunction
  task automatic run(input logic [ML*8-1:0] m, input int len, input logic lbl, input logic [D-1:0] hh, input logic [D-1:0] sh, input bit poke);
    int n;
    bit valid;
    logic [1:0] prev, er;
    logic [D-1:0] q;
    int eh, es;
    valid = len >= 3 && len <= ML;
    @(negedge clk);
    msg = m; length = LW'(len); label = lbl; ham_hv = hh; spam_hv = sh; start = 1;
    prev = result[2];
    @(posedge clk); #1;
    start = 0; msg = rand_msg(); length = 8'($urandom); label = ~lbl; ham_hv = ~hh; spam_hv = ~sh;
    n = 0;
    while (!done[2] && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        check("busy_after_start", busy[2], 1);
        check("result_hold", result[2], prev);
        if (poke) start = 1;
      end
      if (n == 2) start = 0;
    end
    check($sformatf("latency_len%0d", len), n, valid ? len + 3 : 2);
    for (int k = 0; k < 3; k++) begin
      q = valid ? model_query(seed_of(k), m, len) : '0;
      eh = valid ? popc(q ^ hh) : 0;
      es = valid ? popc(q ^ sh) : 0;
      er = !valid ? 2'b10 : (eh <= es ? 2'b00 : 2'b01);
      check($sformatf("result_s%0d_len%0d", k, len), result[k], er);
      check($sformatf("dist_ham_s%0d", k), dist_ham[k], eh);
      check($sformatf("dist_spam_s%0d", k), dist_spam[k], es);
      check($sformatf("correct_s%0d", k), correct[k], valid && er[0] == lbl);
      check($sformatf("done_s%0d", k), done[k], 1);
    end
    @(posedge clk); #1;
    check("done_pulse", done[2], 0);
    check("busy_idle", busy[2], 0);
  endtask
  initial begin
    logic [D-1:0] t;
    int seen, len;
    reset = 0; start = 0; msg = '0; length = '0; label = 0; ham_hv = '0; spam_hv = '0;
    #2 reset = 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_result%0d", k), result[k], 2'b11);
      check($sformatf("rst_busy%0d", k), busy[k], 0);
      check($sformatf("rst_done%0d", k), done[k], 0);
      check($sformatf("rst_dist%0d", k), {dist_ham[k], dist_spam[k]}, 0);
      check($sformatf("rst_correct%0d", k), correct[k], 0);
    end
    @(negedge clk); @(negedge clk);
    reset = 0;
    run(pack("hello"), 5, 0, '0, '1, 0);
    check("hello_seed0_result", result[0], 2'b00);
    check("hello_seed0_dist_spam", dist_spam[0], 256);
    run(pack("abcd"), 4, 0, '0, '1, 0);
    check("ones_seed_result", result[1], 2'b01);
    check("ones_seed_dist_ham", dist_ham[1], 256);
    run(rand_msg(), 2, 1, rand_hv(), rand_hv(), 0);
    run(rand_msg(), 0, 0, rand_hv(), rand_hv(), 0);
    run(rand_msg(), 161, 1, rand_hv(), rand_hv(), 0);
    t = rand_hv();
    run(rand_msg(), 160, 1, t, t, 0);
    check("tie_result", result[2], 2'b00);
    t = model_query(S2, pack("aaa"), 3);
    run(pack("aaa"), 3, 0, t, ~t, 1);
    check("aaa_dist_ham", dist_ham[2], 0);
    check("aaa_dist_spam", dist_spam[2], 256);
    @(negedge clk);
    msg = rand_msg(); length = 20; label = 1; ham_hv = rand_hv(); spam_hv = rand_hv(); start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1 reset = 1;
    #1;
    check("abort_busy", busy[2], 0);
    check("abort_result", result[2], 2'b11);
    check("abort_done", done[2], 0);
    check("abort_dist", dist_ham[2], 0);
    @(negedge clk);
    reset = 0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      seen += int'(done[2]);
    end
    check("abort_no_done", seen, 0);
    for (int r = 0; r < 10; r++) begin
      len = $urandom_range(0, 7) == 0 ? $urandom_range(0, 255) : $urandom_range(3, 24);
      run(rand_msg(), len, 1'($urandom), rand_hv(), rand_hv(), 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
